// File: rtl/wb_ext_arbiter.sv
// Round-robin Wishbone arbiter: merges NODES tile master lanes onto one shared
// slave port. A per-grant watchdog aborts accesses the slave never terminates.

module wb_ext_arbiter_lane (
   input  logic        route_i,
   input  logic        force_err_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   input  logic [31:0] s_dat_i,
   output logic        ack_o,
   output logic        err_o,
   output logic        rty_o,
   output logic [31:0] dat_o
);
   assign ack_o = route_i & s_ack_i;
   assign err_o = (route_i & s_err_i) | force_err_i;
   assign rty_o = route_i & s_rty_i;
   assign dat_o = route_i ? s_dat_i : '0;
endmodule

module wb_ext_arbiter #(
   parameter int NODES   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NODES*32-1:0] m_adr_i,
   input  logic [NODES*32-1:0] m_dat_i,
   input  logic [NODES*4-1:0]  m_sel_i,
   input  logic [NODES-1:0]    m_cyc_i,
   input  logic [NODES-1:0]    m_stb_i,
   input  logic [NODES-1:0]    m_we_i,
   input  logic [NODES-1:0]    m_cab_i,
   input  logic [NODES*3-1:0]  m_cti_i,
   input  logic [NODES*2-1:0]  m_bte_i,
   output logic [NODES-1:0]    m_ack_o,
   output logic [NODES-1:0]    m_err_o,
   output logic [NODES-1:0]    m_rty_o,
   output logic [NODES*32-1:0] m_dat_o,
   output logic [31:0]         s_adr_o,
   output logic [31:0]         s_dat_o,
   output logic [3:0]          s_sel_o,
   output logic [2:0]          s_cti_o,
   output logic [1:0]          s_bte_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic                s_cab_o,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   input  logic                s_rty_i,
   input  logic [31:0]         s_dat_i,
   output logic [NODES-1:0]    grant_o,
   output logic                timeout_o
);
   localparam int LW = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic [1:0]  bte;
      logic        we;
      logic        cab;
      logic        cyc;
      logic        stb;
   } wb_req_t;

   logic [1:0]    state_q, state_d;
   logic [LW-1:0] owner_q, owner_d;
   logic [LW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          abort_first_q, abort_first_d;

   wb_req_t       own_req;
   logic          in_grant;
   logic          slv_resp;
   logic          found;
   logic [LW-1:0] winner;

   assign in_grant = (state_q == S_GRANT);
   assign slv_resp = s_ack_i | s_err_i | s_rty_i;

   always_comb begin
      own_req.adr = m_adr_i[int'(owner_q)*32 +: 32];
      own_req.dat = m_dat_i[int'(owner_q)*32 +: 32];
      own_req.sel = m_sel_i[int'(owner_q)*4 +: 4];
      own_req.cti = m_cti_i[int'(owner_q)*3 +: 3];
      own_req.bte = m_bte_i[int'(owner_q)*2 +: 2];
      own_req.we  = m_we_i[owner_q];
      own_req.cab = m_cab_i[owner_q];
      own_req.cyc = m_cyc_i[owner_q];
      own_req.stb = m_stb_i[owner_q];
   end

   // Search upward from last+1 so the previous winner is considered last.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = last_q;
      for (int i = 1; i <= NODES; i++) begin
         idx = (int'(last_q) + i) % NODES;
         if (!found && m_cyc_i[idx]) begin
            found  = 1'b1;
            winner = LW'(idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      cnt_d         = '0;
      abort_first_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               owner_d = winner;
               last_d  = winner;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!own_req.cyc) begin
               state_d = S_IDLE;
            end else if (TIMEOUT > 0 && s_stb_o && !slv_resp) begin
               if (cnt_q == CNT_LAST) begin
                  state_d       = S_ABORT;
                  abort_first_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_ABORT: begin
            if (!own_req.cyc) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         owner_q       <= '0;
         last_q        <= LW'(NODES - 1);
         cnt_q         <= '0;
         abort_first_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         abort_first_q <= abort_first_d;
      end
   end

   // Shared port mirrors the owner only while granted; cyc/stb drop with owner cyc.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_cti_o = '0;
      s_bte_o = '0;
      s_we_o  = 1'b0;
      s_cab_o = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (in_grant) begin
         s_adr_o = own_req.adr;
         s_dat_o = own_req.dat;
         s_sel_o = own_req.sel;
         s_cti_o = own_req.cti;
         s_bte_o = own_req.bte;
         s_we_o  = own_req.we;
         s_cab_o = own_req.cab;
         s_cyc_o = own_req.cyc;
         s_stb_o = own_req.cyc & own_req.stb;
      end
   end

   always_comb begin
      grant_o = '0;
      if (state_q != S_IDLE) grant_o[owner_q] = 1'b1;
   end

   assign timeout_o = (state_q == S_ABORT) && abort_first_q;

   for (genvar n = 0; n < NODES; n++) begin : g_lane
      wb_ext_arbiter_lane u_lane (
         .route_i     (in_grant && (owner_q == LW'(n))),
         .force_err_i (timeout_o && (owner_q == LW'(n))),
         .s_ack_i     (s_ack_i),
         .s_err_i     (s_err_i),
         .s_rty_i     (s_rty_i),
         .s_dat_i     (s_dat_i),
         .ack_o       (m_ack_o[n]),
         .err_o       (m_err_o[n]),
         .rty_o       (m_rty_o[n]),
         .dat_o       (m_dat_o[n*32 +: 32])
      );
   end
endmodule

// File: doc/wb_ext_arbiter.md
# wb_ext_arbiter

Round-robin Wishbone arbiter that merges the per-tile external bus ports (`wb_ext_*`, one lane per compute tile, packed `NODES` wide) of the all-compute-tile system onto a single shared external memory/peripheral port. It sits directly downstream of the system top and consumes its `wb_ext_*` outputs. It returns `ack`/`err`/`rty`/read data to the owning tile only. A watchdog terminates slave accesses that never complete.

## Interface
- `NODES`, 4, number of tile lanes (≥1)
- `TIMEOUT`, 255, cycles without slave response before forced error; 0 disables the watchdog
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; asynchronous, active-low (0 = reset)
- `m_adr_i`  in  NODES*32  per-lane address; lane n = bits [(n+1)*32-1:n*32], same packing for all vectors
- `m_dat_i`  in  NODES*32  per-lane write data
- `m_sel_i`  in  NODES*4  per-lane byte select
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_cab_i`  in  NODES  per-lane control
- `m_cti_i`  in  NODES*3  per-lane cycle type
- `m_bte_i`  in  NODES*2  per-lane burst type
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  NODES  per-lane termination
- `m_dat_o`  out  NODES*32  per-lane read data
- `s_adr_o`  out  32  shared port: address
- `s_dat_o`  out  32  shared port: write data
- `s_sel_o`  out  4  shared port: byte select
- `s_cti_o`  out  3  shared port: cycle type
- `s_bte_o`  out  2  shared port: burst type
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_cab_o`  out  1  shared port: control
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1  shared port: slave termination
- `s_dat_i`  in  32  shared port: read data
- `grant_o`  out  NODES  one-hot current owner; all-zero when idle
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM has three states: IDLE, GRANT, ABORT.
- IDLE:
  - A lane requests when its `m_cyc_i` is 1.
  - The winner is the first requesting lane searching upward from `last+1` (mod NODES).
  - Register `owner` = winner and `last` = winner, then go to GRANT.
  - No requests: stay in IDLE.
- GRANT:
  - `s_*` outputs are combinational copies of the owner lane's `m_*` inputs.
  - `m_ack_o`/`m_err_o`/`m_rty_o` of the owner lane = `s_ack_i`/`s_err_i`/`s_rty_i`.
  - `m_dat_o` owner lane = `s_dat_i`.
  - All other lanes' outputs are 0.
  - The grant is held for the whole cycle, including bursts (`cti` 010), until the owner's `m_cyc_i` = 0.
  - When the owner's `m_cyc_i` = 0: `s_cyc_o`/`s_stb_o` = 0 in that cycle, next state is IDLE.
- Watchdog (TIMEOUT > 0), counter width clog2(TIMEOUT+1):
  - Counts GRANT cycles with `s_stb_o`=1 and none of `s_ack_i`/`s_err_i`/`s_rty_i` asserted.
  - Clears on any termination, on `stb` low, and on leaving GRANT.
  - When count == TIMEOUT-1 and still no response, go to ABORT.
- ABORT:
  - First cycle only: `m_err_o[owner]`=1 and `timeout_o`=1.
  - Throughout ABORT: `s_cyc_o`=`s_stb_o`=0 and slave responses are ignored.
  - Stay in ABORT until the owner's `m_cyc_i`=0, then go to IDLE.
- Outside GRANT, all `s_*` outputs and all `m_*_o` outputs are 0.
- Simultaneous requests: the round-robin pointer guarantees each requester is served within NODES grants.
- A non-owner dropping `cyc` has no effect. Owner `cyc` dropping mid-burst ends the grant; no termination is synthesised.
- Owner `m_stb_i` low while `cyc` is high: the grant is kept and `s_stb_o` = 0.

## Timing
- Reset (async assert): state=IDLE, `owner`=0, `last`=NODES-1 (lane 0 wins first), counter=0. `grant_o`=0, `timeout_o`=0, all `s_*`/`m_*_o` = 0 immediately. Deassertion is synchronous to `clk`.
- Reset mid-transaction: the shared bus drops at once with no termination to the tile.
- Arbitration latency: request seen in IDLE at edge t → `grant_o`/`s_cyc_o` valid from t+1.
- Paths are combinational in both directions, zero cycles: `m_*` → `s_*`, and `s_ack_i`/`s_dat_i` → `m_ack_o`/`m_dat_o`. A zero-wait slave completes single accesses in the grant cycle.
- Bus turnaround: at least one IDLE cycle between successive grants.
- Watchdog: with no slave response, `m_err_o` is asserted exactly TIMEOUT cycles after the first `s_stb_o`=1 cycle.

## Test plan
- Single read:
  - Stimulus: lane 2 `cyc`/`stb`=1, adr 0x1000; slave acks in the same cycle with data 0xDEADBEEF.
  - Response: `grant_o`=0100 one cycle after the request; `m_ack_o`=0100; lane 2 `m_dat_o`=0xDEADBEEF; other lanes 0.
- Fairness:
  - Stimulus: all 4 lanes request continuously, each doing single accesses then dropping `cyc`.
  - Response: grant order 0,1,2,3,0; one IDLE cycle between grants.
- Burst hold:
  - Stimulus: lane 1 incrementing burst of 4 (`cti` 010,010,010,111) while lane 0 requests.
  - Response: 4 acks routed to lane 1; lane 0 granted only after lane 1 drops `cyc`.
- Timeout:
  - Stimulus: TIMEOUT=8, lane 3 write, slave never responds.
  - Response: `m_err_o[3]` and `timeout_o` pulse 8 cycles after `s_stb_o` rose; `s_cyc_o`=0 from then on; IDLE after lane 3 drops `cyc`.
- Async reset during a burst:
  - Stimulus: `rst`=0 mid-burst on lane 2.
  - Response: all outputs 0 immediately. After release, a request from lane 2 alongside lane 0 is granted to lane 0 first.
- Error/retry pass-through:
  - Stimulus: slave asserts `s_rty_i`, then `s_err_i`.
  - Response: only the owner lane sees the pulses; watchdog count resets each time.
